// File: rtl/range_finder_button_ctrl_pkg.sv
// rtl/range_finder_button_ctrl_pkg.sv - shared register addresses and debounce state type
package range_finder_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/range_finder_button_ctrl_if.sv
// rtl/range_finder_button_ctrl_if.sv - Avalon-MM slave register bus bundle
interface range_finder_button_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/range_finder_button_ctrl_debounce.sv
// rtl/range_finder_button_ctrl_debounce.sv - per-button debounce FSM with accept pulses
module button_debounce
    import range_finder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_sync,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DB_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    // rise/fall are asserted in the same cycle the new level is committed,
    // so the edge-capture register and the level update on the same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise      = 1'b0;
        fall      = 1'b0;
        case (state)
            DB_STABLE: begin
                if (din_sync != level) begin
                    state_nxt = DB_COUNTING;
                    cnt_nxt   = '0;
                end
            end
            DB_COUNTING: begin
                if (din_sync == level) begin
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                    level_nxt = din_sync;
                    rise      = din_sync;
                    fall      = ~din_sync;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = DB_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/range_finder_button_ctrl.sv
// rtl/range_finder_button_ctrl.sv - debounced push-button PIO with edge capture and irq
module range_finder_button_ctrl
    import range_finder_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    range_finder_button_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]           in_port,
    output logic                       irq
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] qualified;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_port;
            sync_q    <= sync_meta;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .din_sync (sync_q[i]),
            .level    (level[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata[31:WIDTH];
    assign cap_clr      = (wr_en && bus.address == ADDR_EDGECAP) ? wdata : '0;
    // edge_sel is sampled when the debounce accepts, not when counting starts
    assign qualified    = (rise & ~edge_sel) | (fall & edge_sel);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = level;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            ADDR_EDGESEL: rd_mux[WIDTH-1:0] = edge_sel;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask      <= '0;
            edge_sel     <= '0;
            edgecap      <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
            if (wr_en && bus.address == ADDR_EDGESEL) begin
                edge_sel <= wdata;
            end
            // a new qualified edge overrides a same-cycle clear
            edgecap      <= (edgecap & ~cap_clr) | qualified;
            irq          <= |(edgecap & irqmask);
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_range_finder_button_ctrl.sv
// tb/tb_range_finder_button_ctrl.sv - randomized and directed bench with reference model
module tb_range_finder_button_ctrl;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    range_finder_button_ctrl_if bus ();

    range_finder_button_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_s1, m_s2, m_level, m_mask, m_cap, m_sel;
    int           m_run [W];
    logic         m_irq;
    logic [31:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_mask = '0; m_cap = '0; m_sel = '0;
        m_irq = 1'b0; m_rd = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endfunction

    // A bit's level flips once the synchronised input has disagreed with it
    // for D+1 consecutive samples; any agreeing sample restarts the run.
    function automatic void model_edge();
        logic [W-1:0] new_level, flipped, qual, clr;
        logic         wr;
        if (!reset_n) begin
            model_reset();
            return;
        end
        new_level = m_level;
        for (int i = 0; i < W; i++) begin
            if (m_s2[i] != m_level[i]) begin
                if (m_run[i] == D) begin
                    new_level[i] = m_s2[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        flipped = new_level ^ m_level;
        qual    = flipped & (new_level ^ m_sel);
        wr      = bus.chipselect && !bus.write_n;
        clr     = (wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
        case (bus.address)
            2'd0:    m_rd = 32'(m_level);
            2'd1:    m_rd = 32'(m_mask);
            2'd2:    m_rd = 32'(m_cap);
            default: m_rd = 32'(m_sel);
        endcase
        m_irq = |(m_cap & m_mask);
        m_cap = (m_cap & ~clr) | qual;
        if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
        if (wr && bus.address == 2'd3) m_sel  = bus.writedata[W-1:0];
        m_s2    = m_s1;
        m_s1    = in_port;
        m_level = new_level;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("readdata", bus.readdata, m_rd);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_expect(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.address = addr;
        tick();
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = '0;
        reset_n        = 1'b0;
        model_reset();
        ticks(3);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        ticks(2);

        // clean press on bit 0
        bus_write(2'd1, 32'h1);
        in_port = 2'b01;
        ticks(12);
        read_expect("press_data", 2'd0, 32'h1);
        read_expect("press_edgecap", 2'd2, 32'h1);
        check("press_irq", 32'(irq), 32'h1);
        in_port = 2'b00;
        ticks(12);
        bus_write(2'd2, 32'h1);
        tick();
        check("clear_irq", 32'(irq), 32'h0);

        // glitch on bit 1
        in_port = 2'b10;
        ticks(3);
        in_port = 2'b00;
        ticks(10);
        read_expect("glitch_data", 2'd0, 32'h0);
        read_expect("glitch_edgecap", 2'd2, 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // release edge on bit 1
        bus_write(2'd3, 32'h2);
        in_port = 2'b10;
        ticks(12);
        read_expect("release_after_press", 2'd2, 32'h0);
        in_port = 2'b00;
        ticks(12);
        read_expect("release_edgecap", 2'd2, 32'h2);

        // clear write lands on the accepting edge of a bit-0 press
        in_port = 2'b01;
        ticks(6);
        bus_write(2'd2, 32'h1);
        read_expect("race_edgecap", 2'd2, 32'h3);
        bus_write(2'd2, 32'h1);
        tick();
        check("race_clear_irq", 32'(irq), 32'h0);
        read_expect("race_cleared", 2'd2, 32'h2);

        // masking and read latency
        in_port = 2'b00;
        ticks(12);
        in_port = 2'b01;
        ticks(12);
        bus_write(2'd1, 32'h0);
        tick();
        check("mask_off_irq", 32'(irq), 32'h0);
        bus_write(2'd1, 32'h2);
        tick();
        check("mask_on_irq", 32'(irq), 32'h1);
        read_expect("irqmask_read", 2'd1, 32'h2);

        // reset while bit 1 is counting, both buttons held through it
        in_port = 2'b11;
        ticks(4);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_readdata", bus.readdata, 32'h0);
        check("async_reset_irq", 32'(irq), 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(20);
        read_expect("post_reset_data", 2'd0, 32'h3);
        read_expect("post_reset_edgecap", 2'd2, 32'h3);

        // randomized traffic checked cycle by cycle against the model
        for (int step = 0; step < 120; step++) begin
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus_write(2'($urandom), $urandom);
            end else begin
                bus.address = 2'($urandom);
            end
            ticks($urandom_range(1, 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
